// File: rtl/load_store_buffer.sv
// load_store_buffer
// Receiving end of the LSB reservation-station issue interface. Memory ops
// arrive in program order with ready operands. Each op gets its effective
// address, is queued in a circular FIFO, and executes strictly from the head.
// Loads go to memory as soon as they reach the head, and their extended result
// is broadcast on the LSB CDB for one cycle. A store tells the ROB, for one
// cycle, that its address and data are ready. It waits at the head until the
// ROB commits it, then writes memory.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   rdy                      global enable; low freezes all state and outputs
//   clear                    mispredict flush (keeps committed stores only)
//   LSB_valid/op/reg1/reg2/reg_des_rob/imm   issue interface from the LSB RS
//   LSB_is_full              stall to ID, raised two entries early
//   store_ready_valid/tag    one-cycle store-ready pulse to the ROB
//   ROB_commit_valid/tag     ROB commit of a store
//   mem_req_*                single outstanding memory request
//   mem_done, mem_rdata      memory completion pulse and load data
//   LSB_cdb_valid/tag/data   load result broadcast
//
// The op code values below must match the shared op define encoding.
module load_store_buffer #(
   parameter int DEPTH     = 16,
   parameter int TAG_WIDTH = 4,
   parameter int OP_WIDTH  = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 clear,
   input  logic                 LSB_valid,
   input  logic [OP_WIDTH-1:0]  LSB_op,
   input  logic [31:0]          LSB_reg1,
   input  logic [31:0]          LSB_reg2,
   input  logic [TAG_WIDTH-1:0] LSB_reg_des_rob,
   input  logic [31:0]          LSB_imm,
   output logic                 LSB_is_full,
   output logic                 store_ready_valid,
   output logic [TAG_WIDTH-1:0] store_ready_tag,
   input  logic                 ROB_commit_valid,
   input  logic [TAG_WIDTH-1:0] ROB_commit_tag,
   output logic                 mem_req_valid,
   output logic                 mem_req_write,
   output logic [31:0]          mem_req_addr,
   output logic [31:0]          mem_req_wdata,
   output logic [1:0]           mem_req_size,
   input  logic                 mem_done,
   input  logic [31:0]          mem_rdata,
   output logic                 LSB_cdb_valid,
   output logic [TAG_WIDTH-1:0] LSB_cdb_tag,
   output logic [31:0]          LSB_cdb_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [OP_WIDTH-1:0] OP_LB  = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_LH  = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OP_LW  = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] OP_LBU = OP_WIDTH'(4);
   localparam logic [OP_WIDTH-1:0] OP_LHU = OP_WIDTH'(5);
   localparam logic [OP_WIDTH-1:0] OP_SB  = OP_WIDTH'(6);
   localparam logic [OP_WIDTH-1:0] OP_SH  = OP_WIDTH'(7);
   localparam logic [OP_WIDTH-1:0] OP_SW  = OP_WIDTH'(8);

   typedef enum logic [0:0] {IDLE, WAIT_MEM} state_t;

   function automatic logic is_store(input logic [OP_WIDTH-1:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic [1:0] size_of(input logic [OP_WIDTH-1:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 2'd0;
         OP_LH, OP_LHU, OP_SH: return 2'd1;
         default:              return 2'd2;
      endcase
   endfunction

   function automatic logic [31:0] extend_load(input logic [OP_WIDTH-1:0] op,
                                               input logic [31:0] raw);
      case (op)
         OP_LB:   return {{24{raw[7]}}, raw[7:0]};
         OP_LBU:  return {24'd0, raw[7:0]};
         OP_LH:   return {{16{raw[15]}}, raw[15:0]};
         OP_LHU:  return {16'd0, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   state_t state, state_next;

   logic [PTR_W-1:0]    head, tail;
   logic [CNT_W-1:0]    count;
   logic [DEPTH-1:0]    ent_valid, ent_committed;
   logic [OP_WIDTH-1:0] ent_op   [DEPTH];
   logic [TAG_WIDTH-1:0] ent_tag [DEPTH];
   logic [31:0]         ent_addr [DEPTH];
   logic [31:0]         ent_data [DEPTH];

   // Set when a flush discards the load that is already out at memory, so its
   // completion neither pops the (already rewound) queue nor broadcasts.
   logic req_killed;

   logic [OP_WIDTH-1:0] head_op;
   logic                accept;
   logic                issue, done, pop, broadcast;
   logic [DEPTH-1:0]    commit_hit, eff_committed, keep_mask;
   logic [CNT_W-1:0]    n_keep;
   logic [PTR_W-1:0]    scan_idx;
   logic                run;

   assign head_op     = ent_op[head];
   assign accept      = LSB_valid && !clear && (count != CNT_W'(DEPTH));
   assign LSB_is_full = (count >= CNT_W'(DEPTH - 2));

   // A same-cycle commit counts as already applied when a flush decides which
   // entries survive.
   always_comb begin
      commit_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         commit_hit[i] = ROB_commit_valid && ent_valid[i] && is_store(ent_op[i]) &&
                         (ent_tag[i] == ROB_commit_tag);
      end
      eff_committed = ent_committed | commit_hit;
   end

   // Committed stores sit contiguously at the head, so a flush keeps the run of
   // committed entries starting at head and drops everything after it.
   always_comb begin
      keep_mask = '0;
      n_keep    = '0;
      run       = 1'b1;
      scan_idx  = head;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = head + PTR_W'(i);
         if (run && ent_valid[scan_idx] && eff_committed[scan_idx]) begin
            keep_mask[scan_idx] = 1'b1;
            n_keep              = n_keep + CNT_W'(1);
         end else begin
            run = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next state plus the per-cycle control decisions. A load at the head
   // waiting to issue while a flush occurs is discarded, so it must not issue.
   // A completing load that the flush discards does not pop.
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      done       = 1'b0;
      pop        = 1'b0;
      broadcast  = 1'b0;
      if (rdy) begin
         case (state)
            IDLE: begin
               if (ent_valid[head]) begin
                  if (is_store(head_op)) issue = ent_committed[head];
                  else                   issue = !clear;
               end
               if (issue) state_next = WAIT_MEM;
            end
            WAIT_MEM: begin
               if (mem_done) begin
                  done       = 1'b1;
                  pop        = !req_killed && !(clear && !mem_req_write);
                  broadcast  = pop && !mem_req_write && !clear;
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Queue storage, pointers, memory request and broadcast registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head              <= '0;
         tail              <= '0;
         count             <= '0;
         ent_valid         <= '0;
         ent_committed     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_op[i]   <= '0;
            ent_tag[i]  <= '0;
            ent_addr[i] <= '0;
            ent_data[i] <= '0;
         end
         req_killed        <= 1'b0;
         store_ready_valid <= 1'b0;
         store_ready_tag   <= '0;
         mem_req_valid     <= 1'b0;
         mem_req_write     <= 1'b0;
         mem_req_addr      <= '0;
         mem_req_wdata     <= '0;
         mem_req_size      <= '0;
         LSB_cdb_valid     <= 1'b0;
         LSB_cdb_tag       <= '0;
         LSB_cdb_data      <= '0;
      end else if (rdy) begin
         store_ready_valid <= accept && is_store(LSB_op);
         if (accept && is_store(LSB_op)) store_ready_tag <= LSB_reg_des_rob;

         LSB_cdb_valid <= broadcast;
         if (broadcast) begin
            LSB_cdb_tag  <= ent_tag[head];
            LSB_cdb_data <= extend_load(head_op, mem_rdata);
         end

         for (int i = 0; i < DEPTH; i++) begin
            if (commit_hit[i]) ent_committed[i] <= 1'b1;
         end

         if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (!keep_mask[i]) ent_valid[i] <= 1'b0;
            end
            tail  <= head + n_keep[PTR_W-1:0];
            count <= n_keep - CNT_W'(pop);
         end else begin
            if (accept) begin
               ent_valid[tail]     <= 1'b1;
               ent_committed[tail] <= 1'b0;
               ent_op[tail]        <= LSB_op;
               ent_tag[tail]       <= LSB_reg_des_rob;
               ent_addr[tail]      <= LSB_reg1 + LSB_imm;
               ent_data[tail]      <= LSB_reg2;
               tail                <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(accept) - CNT_W'(pop);
         end

         if (pop) begin
            ent_valid[head] <= 1'b0;
            head            <= head + PTR_W'(1);
         end

         if (issue) begin
            mem_req_valid <= 1'b1;
            mem_req_write <= is_store(head_op);
            mem_req_addr  <= ent_addr[head];
            mem_req_wdata <= is_store(head_op) ? ent_data[head] : 32'd0;
            mem_req_size  <= size_of(head_op);
            req_killed    <= 1'b0;
         end else if (done) begin
            mem_req_valid <= 1'b0;
            req_killed    <= 1'b0;
         end else if (state == WAIT_MEM && clear && !mem_req_write) begin
            req_killed <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_load_store_buffer.sv
// tb_load_store_buffer
// Directed bench for load_store_buffer: reset values, load issue/broadcast,
// load extension, store announce/commit/write, store-before-load ordering,
// full/drop behaviour, flush, rdy freeze and asynchronous reset.
module tb_load_store_buffer;

   localparam logic [5:0] OP_LB  = 6'd1;
   localparam logic [5:0] OP_LH  = 6'd2;
   localparam logic [5:0] OP_LW  = 6'd3;
   localparam logic [5:0] OP_LBU = 6'd4;
   localparam logic [5:0] OP_LHU = 6'd5;
   localparam logic [5:0] OP_SB  = 6'd6;
   localparam logic [5:0] OP_SW  = 6'd8;

   logic        clk = 1'b0;
   logic        rst, rdy, clear;
   logic        LSB_valid;
   logic [5:0]  LSB_op;
   logic [31:0] LSB_reg1, LSB_reg2, LSB_imm;
   logic [3:0]  LSB_reg_des_rob;
   logic        LSB_is_full;
   logic        store_ready_valid;
   logic [3:0]  store_ready_tag;
   logic        ROB_commit_valid;
   logic [3:0]  ROB_commit_tag;
   logic        mem_req_valid, mem_req_write;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [1:0]  mem_req_size;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic        LSB_cdb_valid;
   logic [3:0]  LSB_cdb_tag;
   logic [31:0] LSB_cdb_data;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   load_store_buffer #(.DEPTH(16), .TAG_WIDTH(4), .OP_WIDTH(6)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .LSB_valid(LSB_valid), .LSB_op(LSB_op), .LSB_reg1(LSB_reg1),
      .LSB_reg2(LSB_reg2), .LSB_reg_des_rob(LSB_reg_des_rob), .LSB_imm(LSB_imm),
      .LSB_is_full(LSB_is_full),
      .store_ready_valid(store_ready_valid), .store_ready_tag(store_ready_tag),
      .ROB_commit_valid(ROB_commit_valid), .ROB_commit_tag(ROB_commit_tag),
      .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_req_size(mem_req_size), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .LSB_cdb_valid(LSB_cdb_valid), .LSB_cdb_tag(LSB_cdb_tag),
      .LSB_cdb_data(LSB_cdb_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one op for exactly one active edge.
   task automatic issue_op(input logic [5:0] op, input logic [3:0] tag,
                           input logic [31:0] base, input logic [31:0] imm,
                           input logic [31:0] wd);
      LSB_valid       = 1'b1;
      LSB_op          = op;
      LSB_reg_des_rob = tag;
      LSB_reg1        = base;
      LSB_imm         = imm;
      LSB_reg2        = wd;
      tick();
      LSB_valid = 1'b0;
   endtask

   // Issues a load into an empty queue, answers it, and returns what the
   // request looked like and what the CDB showed the cycle after mem_done.
   task automatic run_load(input logic [5:0] op, input logic [3:0] tag,
                           input logic [31:0] rdata,
                           output logic req_v, output logic cdb_v,
                           output logic [3:0] cdb_t, output logic [31:0] cdb_d);
      issue_op(op, tag, 32'h0000_0100, 32'h0, 32'h0);
      tick();
      req_v     = mem_req_valid;
      mem_done  = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_done = 1'b0;
      cdb_v    = LSB_cdb_valid;
      cdb_t    = LSB_cdb_tag;
      cdb_d    = LSB_cdb_data;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      vectors++;
      if (mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_req_valid got %b want 0", mem_req_valid); end
      vectors++;
      if (store_ready_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_store_ready got %b want 0", store_ready_valid); end
      vectors++;
      if (LSB_cdb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cdb_valid got %b want 0", LSB_cdb_valid); end
      vectors++;
      if (LSB_is_full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_is_full got %b want 0", LSB_is_full); end
      vectors++;
      if (mem_req_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_addr got %h want 0", mem_req_addr); end
      #2 rst = 1'b0;
      tick();
   endtask

   task automatic test_load();
      issue_op(OP_LW, 4'd3, 32'h0000_1000, 32'h0000_0010, 32'h0);
      tick();
      vectors++;
      if (mem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL load_req_valid got %b want 1", mem_req_valid); end
      vectors++;
      if (mem_req_write !== 1'b0) begin miscompares++; $display("[TB] FAIL load_req_write got %b want 0", mem_req_write); end
      vectors++;
      if (mem_req_addr !== 32'h0000_1010) begin miscompares++; $display("[TB] FAIL load_req_addr got %h want 00001010", mem_req_addr); end
      vectors++;
      if (mem_req_size !== 2'd2) begin miscompares++; $display("[TB] FAIL load_req_size got %0d want 2", mem_req_size); end
      mem_done  = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_done = 1'b0;
      vectors++;
      if (LSB_cdb_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL load_cdb_valid got %b want 1", LSB_cdb_valid); end
      vectors++;
      if (LSB_cdb_tag !== 4'd3) begin miscompares++; $display("[TB] FAIL load_cdb_tag got %0d want 3", LSB_cdb_tag); end
      vectors++;
      if (LSB_cdb_data !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL load_cdb_data got %h want deadbeef", LSB_cdb_data); end
      vectors++;
      if (mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL load_req_drop got %b want 0", mem_req_valid); end
      tick();
      vectors++;
      if (LSB_cdb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL load_cdb_one_cycle got %b want 0", LSB_cdb_valid); end
   endtask

   task automatic test_extension();
      logic [5:0]  ops  [4] = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
      logic [31:0] raws [4] = '{32'h0000_0080, 32'h0000_0080, 32'h0000_8001, 32'h0000_8001};
      logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
      logic        rv, cv;
      logic [3:0]  ct;
      logic [31:0] cd;
      for (int i = 0; i < 4; i++) begin
         run_load(ops[i], 4'(i + 8), raws[i], rv, cv, ct, cd);
         vectors++;
         if (rv !== 1'b1) begin miscompares++; $display("[TB] FAIL ext%0d_req got %b want 1", i, rv); end
         vectors++;
         if (cv !== 1'b1) begin miscompares++; $display("[TB] FAIL ext%0d_cdb_valid got %b want 1", i, cv); end
         vectors++;
         if (cd !== exps[i]) begin miscompares++; $display("[TB] FAIL ext%0d_data got %h want %h", i, cd, exps[i]); end
      end
   endtask

   task automatic test_store();
      int waited;
      issue_op(OP_SW, 4'd5, 32'h0000_2000, 32'h0000_0004, 32'h1234_5678);
      vectors++;
      if (store_ready_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL store_ready_pulse got %b want 1", store_ready_valid); end
      vectors++;
      if (store_ready_tag !== 4'd5) begin miscompares++; $display("[TB] FAIL store_ready_tag got %0d want 5", store_ready_tag); end
      tick();
      vectors++;
      if (store_ready_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL store_ready_one_cycle got %b want 0", store_ready_valid); end
      tick();
      tick();
      vectors++;
      if (mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL store_no_req_before_commit got %b want 0", mem_req_valid); end
      ROB_commit_valid = 1'b1;
      ROB_commit_tag   = 4'd5;
      tick();
      ROB_commit_valid = 1'b0;
      waited = 0;
      while (mem_req_valid !== 1'b1 && waited < 4) begin tick(); waited++; end
      vectors++;
      if (mem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL store_req_timeout got %b want 1", mem_req_valid); end
      vectors++;
      if (mem_req_write !== 1'b1) begin miscompares++; $display("[TB] FAIL store_req_write got %b want 1", mem_req_write); end
      vectors++;
      if (mem_req_addr !== 32'h0000_2004) begin miscompares++; $display("[TB] FAIL store_req_addr got %h want 00002004", mem_req_addr); end
      vectors++;
      if (mem_req_wdata !== 32'h1234_5678) begin miscompares++; $display("[TB] FAIL store_req_wdata got %h want 12345678", mem_req_wdata); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      vectors++;
      if (LSB_cdb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL store_no_cdb got %b want 0", LSB_cdb_valid); end
      tick();
      tick();
      vectors++;
      if (mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL store_popped got %b want 0", mem_req_valid); end
   endtask

   task automatic test_ordering();
      int waited;
      issue_op(OP_SB, 4'd1, 32'h0000_3000, 32'h0000_0001, 32'h0000_00AB);
      issue_op(OP_LW, 4'd2, 32'h0000_3000, 32'h0000_0008, 32'h0);
      tick();
      tick();
      vectors++;
      if (mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL order_load_blocked got %b want 0", mem_req_valid); end
      ROB_commit_valid = 1'b1;
      ROB_commit_tag   = 4'd1;
      tick();
      ROB_commit_valid = 1'b0;
      waited = 0;
      while (mem_req_valid !== 1'b1 && waited < 4) begin tick(); waited++; end
      vectors++;
      if (mem_req_write !== 1'b1 || mem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL order_store_first got v%b w%b want v1 w1", mem_req_valid, mem_req_write); end
      vectors++;
      if (mem_req_addr !== 32'h0000_3001) begin miscompares++; $display("[TB] FAIL order_store_addr got %h want 00003001", mem_req_addr); end
      vectors++;
      if (mem_req_size !== 2'd0) begin miscompares++; $display("[TB] FAIL order_store_size got %0d want 0", mem_req_size); end
      tick();
      tick();
      vectors++;
      if (mem_req_write !== 1'b1 || mem_req_addr !== 32'h0000_3001) begin miscompares++; $display("[TB] FAIL order_store_held got w%b a%h want w1 a00003001", mem_req_write, mem_req_addr); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      vectors++;
      if (mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL order_gap got %b want 0", mem_req_valid); end
      tick();
      vectors++;
      if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== 32'h0000_3008) begin miscompares++; $display("[TB] FAIL order_load_req got v%b w%b a%h want v1 w0 a00003008", mem_req_valid, mem_req_write, mem_req_addr); end
      mem_done  = 1'b1;
      mem_rdata = 32'h0BAD_F00D;
      tick();
      mem_done = 1'b0;
      vectors++;
      if (LSB_cdb_valid !== 1'b1 || LSB_cdb_tag !== 4'd2 || LSB_cdb_data !== 32'h0BAD_F00D) begin miscompares++; $display("[TB] FAIL order_load_cdb got v%b t%0d d%h want v1 t2 d0badf00d", LSB_cdb_valid, LSB_cdb_tag, LSB_cdb_data); end
      tick();
   endtask

   task automatic test_full();
      for (int i = 0; i < 17; i++) begin
         LSB_valid       = 1'b1;
         LSB_op          = OP_SW;
         LSB_reg_des_rob = 4'(i);
         LSB_reg1        = 32'h0000_8000;
         LSB_imm         = 32'(i * 4);
         LSB_reg2        = 32'(i);
         tick();
         if (i == 12) begin
            vectors++;
            if (LSB_is_full !== 1'b0) begin miscompares++; $display("[TB] FAIL full_at13 got %b want 0", LSB_is_full); end
         end
         if (i == 13) begin
            vectors++;
            if (LSB_is_full !== 1'b1) begin miscompares++; $display("[TB] FAIL full_at14 got %b want 1", LSB_is_full); end
         end
         if (i == 15) begin
            vectors++;
            if (store_ready_valid !== 1'b1 || LSB_is_full !== 1'b1) begin miscompares++; $display("[TB] FAIL full_at16 got sr%b full%b want sr1 full1", store_ready_valid, LSB_is_full); end
         end
         if (i == 16) begin
            vectors++;
            if (store_ready_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL full_drop17 got %b want 0", store_ready_valid); end
         end
      end
      LSB_valid = 1'b0;
      vectors++;
      if (mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL full_no_req got %b want 0", mem_req_valid); end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      vectors++;
      if (LSB_is_full !== 1'b0) begin miscompares++; $display("[TB] FAIL full_cleared got %b want 0", LSB_is_full); end
      issue_op(OP_LW, 4'd0, 32'h0000_6000, 32'h0, 32'h0);
      tick();
      vectors++;
      if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_addr !== 32'h0000_6000) begin miscompares++; $display("[TB] FAIL full_after_clear_load got v%b w%b a%h want v1 w0 a00006000", mem_req_valid, mem_req_write, mem_req_addr); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      tick();
   endtask

   task automatic test_clear();
      // In-flight load discarded by the flush.
      issue_op(OP_LW, 4'd7, 32'h0000_4000, 32'h0, 32'h0);
      issue_op(OP_LW, 4'd8, 32'h0000_4004, 32'h0, 32'h0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      vectors++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_4000) begin miscompares++; $display("[TB] FAIL clr_load_held got v%b a%h want v1 a00004000", mem_req_valid, mem_req_addr); end
      mem_done  = 1'b1;
      mem_rdata = 32'h5555_5555;
      tick();
      mem_done = 1'b0;
      vectors++;
      if (LSB_cdb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_load_no_cdb got %b want 0", LSB_cdb_valid); end
      tick();
      tick();
      vectors++;
      if (mem_req_valid !== 1'b0 || LSB_is_full !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_load_empty got v%b full%b want v0 full0", mem_req_valid, LSB_is_full); end
      // Committed store in flight survives the flush, trailing loads do not.
      issue_op(OP_SW, 4'd9, 32'h0000_5000, 32'h0, 32'hCAFE_F00D);
      ROB_commit_valid = 1'b1;
      ROB_commit_tag   = 4'd9;
      issue_op(OP_LW, 4'd10, 32'h0000_5010, 32'h0, 32'h0);
      ROB_commit_valid = 1'b0;
      issue_op(OP_LW, 4'd11, 32'h0000_5020, 32'h0, 32'h0);
      vectors++;
      if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b1 || mem_req_wdata !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL clr_store_req got v%b w%b d%h want v1 w1 dcafef00d", mem_req_valid, mem_req_write, mem_req_wdata); end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      vectors++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_5000) begin miscompares++; $display("[TB] FAIL clr_store_held got v%b a%h want v1 a00005000", mem_req_valid, mem_req_addr); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      vectors++;
      if (mem_req_valid !== 1'b0 || LSB_cdb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_store_done got v%b cdb%b want v0 cdb0", mem_req_valid, LSB_cdb_valid); end
      tick();
      tick();
      vectors++;
      if (mem_req_valid !== 1'b0 || LSB_is_full !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_store_empty got v%b full%b want v0 full0", mem_req_valid, LSB_is_full); end
   endtask

   task automatic test_rdy_freeze();
      issue_op(OP_LW, 4'd4, 32'h0000_7000, 32'h0, 32'h0);
      tick();
      rdy       = 1'b0;
      mem_done  = 1'b1;
      mem_rdata = 32'h0000_0011;
      tick();
      vectors++;
      if (mem_req_valid !== 1'b1 || LSB_cdb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rdy_ignores_done got v%b cdb%b want v1 cdb0", mem_req_valid, LSB_cdb_valid); end
      rdy = 1'b1;
      tick();
      mem_done = 1'b0;
      vectors++;
      if (LSB_cdb_valid !== 1'b1 || LSB_cdb_tag !== 4'd4 || LSB_cdb_data !== 32'h0000_0011) begin miscompares++; $display("[TB] FAIL rdy_cdb got v%b t%0d d%h want v1 t4 d00000011", LSB_cdb_valid, LSB_cdb_tag, LSB_cdb_data); end
      rdy = 1'b0;
      tick();
      tick();
      vectors++;
      if (LSB_cdb_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rdy_cdb_hold got %b want 1", LSB_cdb_valid); end
      rdy = 1'b1;
      tick();
      vectors++;
      if (LSB_cdb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rdy_cdb_release got %b want 0", LSB_cdb_valid); end
   endtask

   task automatic test_async_reset();
      issue_op(OP_LW, 4'd6, 32'h0000_9000, 32'h0, 32'h0);
      tick();
      vectors++;
      if (mem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_pre got %b want 1", mem_req_valid); end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_drop got %b want 0", mem_req_valid); end
      #2 rst = 1'b0;
      tick();
      tick();
      vectors++;
      if (mem_req_valid !== 1'b0 || LSB_cdb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_idle got v%b cdb%b want v0 cdb0", mem_req_valid, LSB_cdb_valid); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; clear = 1'b0;
      LSB_valid = 1'b0; LSB_op = '0; LSB_reg1 = '0; LSB_reg2 = '0;
      LSB_imm = '0; LSB_reg_des_rob = '0;
      ROB_commit_valid = 1'b0; ROB_commit_tag = '0;
      mem_done = 1'b0; mem_rdata = '0;
      test_reset();
      test_load();
      test_extension();
      test_store();
      test_ordering();
      test_full();
      test_clear();
      test_rdy_freeze();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/load_store_buffer.md
Name: load_store_buffer

Overview:
Receiving end of the LSB reservation-station issue interface. Accepts memory ops with ready operands, computes addresses, and queues them in a circular FIFO in program order. Loads execute at the head and broadcast results on the LSB CDB. Stores announce address/data ready to the ROB and write memory only after the ROB commits them.

Parameters:
DEPTH, 16, queue entries (power of two)
TAG_WIDTH, 4, ROB tag width
OP_WIDTH, 6, op code width (shared op define encoding)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global enable; low freezes all state and outputs
clear  in  1  mispredict flush
LSB_valid  in  1  issue strobe from LSB RS
LSB_op  in  OP_WIDTH  LB/LH/LW/LBU/LHU/SB/SH/SW (shared define codes)
LSB_reg1  in  32  base register value
LSB_reg2  in  32  store data
LSB_reg_des_rob  in  TAG_WIDTH  ROB tag
LSB_imm  in  32  sign-extended offset
LSB_is_full  out  1  stall to ID
store_ready_valid  out  1  store ready pulse to ROB
store_ready_tag  out  TAG_WIDTH  tag of ready store
ROB_commit_valid  in  1  ROB committing a store
ROB_commit_tag  in  TAG_WIDTH  committed tag
mem_req_valid  out  1  memory request
mem_req_write  out  1  1 = store
mem_req_addr  out  32  byte address
mem_req_wdata  out  32  store data, low-aligned
mem_req_size  out  2  0 byte, 1 half, 2 word
mem_done  in  1  request complete (one-cycle pulse)
mem_rdata  in  32  load data, low-aligned
LSB_cdb_valid  out  1  load result broadcast
LSB_cdb_tag  out  TAG_WIDTH  result tag
LSB_cdb_data  out  32  extended load value

Behaviour:
- Reset: all outputs are 0. Head, tail, and count are 0. All entries are invalid. State is IDLE.
- rdy=0: no state change; all registered outputs hold.
- Ordering: LSB RS delivers memory ops in program order. The queue preserves arrival order.
- Accept: when LSB_valid=1 at an edge, the tail entry gets:
  - op and tag;
  - addr = LSB_reg1 + LSB_imm (mod 2^32);
  - data = LSB_reg2;
  - committed = 0.
  Then tail++ with wrap and count++.
- Arrival with count==DEPTH: dropped, no state change.
- LSB_is_full = (count >= DEPTH-2), combinational. This leaves slack for ops already in the RS output register.
- Store announce: a store accepted at edge N drives store_ready_valid=1 and store_ready_tag during cycle N+1 only. Otherwise store_ready_valid=0.
- Commit: ROB_commit_valid with a tag equal to a valid store entry sets that entry's committed bit.
- State IDLE, head valid:
  - Load at head: next edge drives mem_req_valid=1, mem_req_write=0, addr, and size. Go to WAIT_MEM.
  - Committed store at head: same, with mem_req_write=1 and wdata=data. Go to WAIT_MEM.
  - Uncommitted store at head: stay in IDLE.
- State WAIT_MEM: mem_req_* held stable until mem_done is sampled 1. At that edge:
  - mem_req_valid goes to 0;
  - head is popped;
  - state returns to IDLE;
  - for a load, LSB_cdb_valid=1 with tag and data during the next cycle only.
  The next request issues no earlier than one edge after return to IDLE.
- Load extension:
  - LB/LH sign-extend bit 7/15;
  - LBU/LHU zero-extend;
  - LW passes through.
- LSB_cdb_valid defaults to 0 every cycle not specified above.
- Simultaneous accept and pop: count is unchanged and both pointers advance.
- Pointer wrap: modulo DEPTH.
- Clear (rdy=1):
  - All uncommitted entries are discarded: tail = head + number of committed entries. Committed stores are contiguous from head.
  - store_ready_valid and LSB_cdb_valid are forced to 0 next cycle.
  - An LSB_valid arriving in the same cycle is ignored.
- Clear while a load is in WAIT_MEM: the request remains until mem_done, then returns to IDLE with no broadcast. The load entry is already discarded.
- Clear while a committed store is in WAIT_MEM: it completes normally.
- A commit arriving in the same cycle as clear is applied before the discard.
- Reset mid-operation: immediate return to reset values; mem_req_valid drops asynchronously.

Test Plan:
- Load: reset, issue LW, reg1=0x1000, imm=0x10, tag 3 -> mem_req addr 0x1010, size 2, write 0. mem_done with rdata 0xDEADBEEF -> one-cycle CDB: tag 3, data 0xDEADBEEF.
- Extension: LB, rdata 0x00000080 -> cdb 0xFFFFFF80. LBU with same rdata -> 0x00000080. LH, rdata 0x00008001 -> 0xFFFF8001.
- Store: SW, tag 5, data 0x12345678 -> store_ready pulse, tag 5, next cycle. No mem_req until ROB_commit tag 5. Then write request addr/data correct, entry popped, no CDB pulse.
- Ordering: SB (tag 1) then LW (tag 2) -> load request not issued until the store is committed and its mem_done returns.
- Full: issue 14 stores without commit -> LSB_is_full=1 at count 14. Fill to 16; a 17th issue is dropped and count stays 16.
- Clear: committed SW at head, two uncommitted loads, one in WAIT_MEM, then pulse clear:
  - in-flight load completes with no CDB pulse;
  - committed store writes memory;
  - queue ends empty and LSB_is_full=0.
